// File: rtl/acc_round_sat_if.sv
// Bus between the filter core side, the formatting stage and the downstream
// sample consumer. The stage is the slave; whoever drives the accumulator
// results and consumes the samples is the master.
interface acc_round_sat_if #(
  parameter int IN_W  = 54,
  parameter int OUT_W = 18
);
  logic                    ena;
  logic                    acc_valid;
  logic signed [IN_W-1:0]  acc_in;
  logic [5:0]              shift;
  logic                    y_valid;
  logic                    y_ready;
  logic signed [OUT_W-1:0] y_out;
  logic                    fifo_full;
  logic                    sat_flag;
  logic                    clr_sat;
  logic [7:0]              drop_cnt;

  modport master (
    output ena, acc_valid, acc_in, shift, y_ready, clr_sat,
    input  y_valid, y_out, fifo_full, sat_flag, drop_cnt
  );

  modport slave (
    input  ena, acc_valid, acc_in, shift, y_ready, clr_sat,
    output y_valid, y_out, fifo_full, sat_flag, drop_cnt
  );
endinterface

// File: rtl/acc_round_sat.sv
// Output formatting stage behind the filter core: round-half-up right shift
// of the wide accumulator, saturation to an OUT_W sample, and a small FIFO
// towards the ready/valid consumer. DEPTH must be a power of two, >= 2.
// Acceptance reserves FIFO space for everything already in flight, so the
// FIFO write never has to be refused and the core never stalls.
module acc_round_sat #(
  parameter int IN_W  = 54,
  parameter int OUT_W = 18,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  acc_round_sat_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;

  localparam logic [5:0] SHIFT_MAX = 6'd35;

  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [IN_W:0]    SAT_MAX = (IN_W+1)'(OUT_MAX);
  localparam logic signed [IN_W:0]    SAT_MIN = (IN_W+1)'(OUT_MIN);

  // Round half up, then arithmetic right shift; one guard bit absorbs the bias.
  function automatic logic signed [IN_W:0] round_shift(
    input logic signed [IN_W-1:0] a,
    input logic [5:0]             s
  );
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] bias;
    ext  = {a[IN_W-1], a};
    bias = '0;
    if (s != 6'd0) bias[s - 6'd1] = 1'b1;
    return (ext + bias) >>> s;
  endfunction

  // Clip to the signed OUT_W range; in-range values are plain truncation.
  function automatic logic signed [OUT_W-1:0] saturate(
    input logic signed [IN_W:0] v
  );
    if (v > SAT_MAX)      return OUT_MAX;
    else if (v < SAT_MIN) return OUT_MIN;
    else                  return v[OUT_W-1:0];
  endfunction

  function automatic logic is_clipped(input logic signed [IN_W:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  // Pipeline and FIFO state
  logic                    r_vld_p1;
  logic                    r_vld_p2;
  logic signed [IN_W:0]    r_data_p1;
  logic signed [OUT_W-1:0] r_data_p2;
  logic                    r_clip_p2;

  logic signed [OUT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_y_valid;
  logic                    r_fifo_full;
  logic                    r_sat_flag;
  logic [7:0]              r_drop_cnt;

  logic [5:0]              w_shift_p0;
  logic signed [IN_W:0]    w_round_p0;
  logic [OW-1:0]           w_occ;
  logic                    w_offer;
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_push;
  logic                    w_pop;
  logic [CW-1:0]           w_count_nxt;

  // ---- p0: clamp shift, round, decide accept/drop against total occupancy
  assign w_shift_p0 = (bus.shift > SHIFT_MAX) ? SHIFT_MAX : bus.shift;
  assign w_round_p0 = round_shift(bus.acc_in, w_shift_p0);

  assign w_occ    = OW'(r_count) + OW'(r_vld_p1) + OW'(r_vld_p2);
  assign w_offer  = bus.ena && bus.acc_valid;
  assign w_accept = w_offer && (w_occ < OW'(DEPTH));
  assign w_drop   = w_offer && (w_occ >= OW'(DEPTH));

  // Write only while the pipeline advances, otherwise a held s2 entry would
  // be written repeatedly.
  assign w_push = bus.ena && r_vld_p2;
  assign w_pop  = r_y_valid && bus.y_ready;

  // Post-edge FIFO count; a simultaneous push and pop cancel.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // Pipeline valid bits advance with ena and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (bus.ena) begin
      r_vld_p1 <= w_accept;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- p1 -> p2: rounded value in s1, saturated sample and clip bit in s2
  always_ff @(posedge clk) begin
    if (bus.ena) begin
      r_data_p1 <= w_round_p0;
      r_data_p2 <= saturate(r_data_p1);
      r_clip_p2 <= is_clipped(r_data_p1);
    end
  end

  // ---- p2 -> FIFO: sample storage, no reset needed behind the valid bits
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_data_p2;
  end

  // FIFO pointers, count and registered status derived from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_y_valid   <= 1'b0;
      r_fifo_full <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_y_valid   <= (w_count_nxt != '0);
      r_fifo_full <= (w_count_nxt == CW'(DEPTH));
    end
  end

  // Sticky clip flag: a clipped sample landing in the FIFO beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_flag <= 1'b0;
    end else if (w_push && r_clip_p2) begin
      r_sat_flag <= 1'b1;
    end else if (bus.clr_sat) begin
      r_sat_flag <= 1'b0;
    end
  end

  // Drop counter, saturating at 255, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Head is forced to zero while empty so reset shows a clean output.
  assign bus.y_out     = r_y_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.y_valid   = r_y_valid;
  assign bus.fifo_full = r_fifo_full;
  assign bus.sat_flag  = r_sat_flag;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_acc_round_sat.sv
// Bench for acc_round_sat: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_acc_round_sat;

  localparam int IN_W  = 54;
  localparam int OUT_W = 18;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  acc_round_sat_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  acc_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_err = 0;
  bit  started = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint v;
    bit     clip;
    int     age;
  } item_t;

  item_t  pipe[$];
  longint fq[$];
  bit     m_sat  = 1'b0;
  int     m_drop = 0;

  int     m_occ;
  bit     m_clip_in;
  bit     m_push_clip;
  item_t  m_new;

  // Expected sample: round half up by 2^s, floor-divide, clamp to 18 bits.
  function automatic longint ref_result(input longint a, input int s, output bit clip);
    longint v;
    int     sc;
    sc = (s > 35) ? 35 : s;
    if (sc > 0) v = (a + (longint'(1) << (sc - 1))) >>> sc;
    else        v = a;
    clip = (v > 131071) || (v < -131072);
    if (v > 131071)  v = 131071;
    if (v < -131072) v = -131072;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe.delete();
      fq.delete();
      m_sat  = 1'b0;
      m_drop = 0;
    end else begin
      m_occ       = fq.size() + pipe.size();
      m_push_clip = 1'b0;
      if (fq.size() != 0 && bus.y_ready) void'(fq.pop_front());
      if (bus.ena) begin
        if (pipe.size() != 0 && pipe[0].age == 1) begin
          fq.push_back(pipe[0].v);
          m_push_clip = pipe[0].clip;
          void'(pipe.pop_front());
        end
        foreach (pipe[i]) pipe[i].age++;
        if (bus.acc_valid) begin
          if (m_occ < DEPTH) begin
            m_new.v    = ref_result(longint'(bus.acc_in), int'(bus.shift), m_clip_in);
            m_new.clip = m_clip_in;
            m_new.age  = 0;
            pipe.push_back(m_new);
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end
      end
      if (m_push_clip)      m_sat = 1'b1;
      else if (bus.clr_sat) m_sat = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("y_valid",   longint'(bus.y_valid),   longint'(fq.size() != 0));
      chk("fifo_full", longint'(bus.fifo_full), longint'(fq.size() == DEPTH));
      chk("sat_flag",  longint'(bus.sat_flag),  longint'(m_sat));
      chk("drop_cnt",  longint'(bus.drop_cnt),  longint'(m_drop));
      if (fq.size() != 0)  chk("y_out", longint'(bus.y_out), fq[0]);
      else if (rst)        chk("y_out_rst", longint'(bus.y_out), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One result in, checked at the head three edges later (FIFO assumed empty).
  task automatic send_chk(input string nm, input longint a, input int sh, input longint exp);
    bus.acc_valid = 1'b1;
    bus.acc_in    = IN_W'(a);
    bus.shift     = 6'(sh);
    step();
    bus.acc_valid = 1'b0;
    step();
    step();
    chk({nm, "_vld"}, longint'(bus.y_valid), 1);
    chk(nm, longint'(bus.y_out), exp);
  endtask

  logic [63:0] r64;
  int          tmp;
  longint      big;

  initial begin
    rst           = 1'b1;
    bus.ena       = 1'b1;
    bus.acc_valid = 1'b0;
    bus.acc_in    = '0;
    bus.shift     = '0;
    bus.y_ready   = 1'b1;
    bus.clr_sat   = 1'b0;
    step();
    started = 1'b1;
    step();
    chk("rst_y_valid",   longint'(bus.y_valid),   0);
    chk("rst_y_out",     longint'(bus.y_out),     0);
    chk("rst_fifo_full", longint'(bus.fifo_full), 0);
    chk("rst_sat_flag",  longint'(bus.sat_flag),  0);
    chk("rst_drop_cnt",  longint'(bus.drop_cnt),  0);
    rst = 1'b0;
    step();

    // Pass-through and rounding
    send_chk("pass", 1000, 0, 1000);
    chk("pass_sat", longint'(bus.sat_flag), 0);
    send_chk("rnd_p1000", 1000, 4, 63);
    send_chk("rnd_m1000", -1000, 4, -62);
    send_chk("rnd_p8", 8, 4, 1);
    send_chk("rnd_m8", -8, 4, 0);

    // Saturation and sticky flag
    big = longint'(1) << 40;
    send_chk("sat_pos", big, 0, 131071);
    chk("sat_set1", longint'(bus.sat_flag), 1);
    bus.clr_sat = 1'b1; step(); bus.clr_sat = 1'b0;
    chk("sat_clr1", longint'(bus.sat_flag), 0);
    send_chk("sat_neg", -big, 0, -131072);
    chk("sat_set2", longint'(bus.sat_flag), 1);
    bus.clr_sat = 1'b1; step(); bus.clr_sat = 1'b0;
    chk("sat_clr2", longint'(bus.sat_flag), 0);
    bus.acc_valid = 1'b1; bus.acc_in = IN_W'(big); bus.shift = 6'd0;
    step();
    bus.acc_valid = 1'b0;
    step();
    bus.clr_sat = 1'b1;
    step();
    bus.clr_sat = 1'b0;
    chk("sat_set_wins", longint'(bus.sat_flag), 1);
    chk("sat_set_wins_y", longint'(bus.y_out), 131071);
    step();

    // Back-pressure: six inputs, four stored, two dropped
    bus.y_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bus.acc_valid = 1'b1; bus.acc_in = IN_W'(k); bus.shift = 6'd0;
      step();
    end
    bus.acc_valid = 1'b0;
    step(); step();
    chk("bp_full", longint'(bus.fifo_full), 1);
    chk("bp_drop", longint'(bus.drop_cnt), 2);
    bus.y_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("bp_order", longint'(bus.y_out), k);
      step();
    end
    chk("bp_empty", longint'(bus.y_valid), 0);

    // Enable low for three cycles while s1/s2 hold data
    bus.acc_valid = 1'b1; bus.acc_in = IN_W'(10);
    step();
    bus.acc_in = IN_W'(20);
    step();
    bus.ena = 1'b0; bus.acc_in = IN_W'(999);
    step(); step(); step();
    chk("ena_hold_vld", longint'(bus.y_valid), 0);
    bus.ena = 1'b1; bus.acc_valid = 1'b0;
    step();
    chk("ena_out1", longint'(bus.y_out), 10);
    step();
    chk("ena_out2", longint'(bus.y_out), 20);
    chk("ena_drop", longint'(bus.drop_cnt), 2);
    step();
    chk("ena_done", longint'(bus.y_valid), 0);

    // Shift clamp
    send_chk("clamp63", longint'(1) << 35, 63, 1);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.ena       = ($urandom_range(0, 9) != 0);
      bus.acc_valid = ($urandom_range(0, 3) != 0);
      bus.y_ready   = ($urandom_range(0, 2) != 0);
      bus.clr_sat   = ($urandom_range(0, 19) == 0);
      bus.shift     = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0: begin
          tmp = int'($urandom_range(0, 400000)) - 200000;
          bus.acc_in = IN_W'(tmp);
        end
        1: begin
          r64 = {$urandom(), $urandom()};
          bus.acc_in = r64[IN_W-1:0];
        end
        2: bus.acc_in = {1'b0, {(IN_W-1){1'b1}}};
        default: bus.acc_in = {1'b1, {(IN_W-1){1'b0}}};
      endcase
      step();
    end

    // Drain, then reset with two samples in the FIFO and one in s1
    bus.ena = 1'b1; bus.acc_valid = 1'b0; bus.y_ready = 1'b1; bus.clr_sat = 1'b0;
    for (int k = 0; k < 8; k++) step();
    bus.y_ready = 1'b0; bus.shift = 6'd0;
    bus.acc_valid = 1'b1; bus.acc_in = IN_W'(5);
    step();
    bus.acc_in = IN_W'(6);
    step();
    bus.acc_valid = 1'b0;
    step();
    bus.acc_valid = 1'b1; bus.acc_in = IN_W'(7);
    step();
    bus.acc_valid = 1'b0;
    chk("pre_rst_vld", longint'(bus.y_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_y_valid",   longint'(bus.y_valid),   0);
    chk("mid_rst_y_out",     longint'(bus.y_out),     0);
    chk("mid_rst_fifo_full", longint'(bus.fifo_full), 0);
    chk("mid_rst_sat_flag",  longint'(bus.sat_flag),  0);
    chk("mid_rst_drop_cnt",  longint'(bus.drop_cnt),  0);
    step();
    rst = 1'b0;
    bus.y_ready = 1'b1;
    send_chk("post_rst", 1000, 0, 1000);
    step();
    chk("post_rst_alone", longint'(bus.y_valid), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
